// File: rtl/tinyalu_sequencer_if.sv
// Bundles the command, response and TinyALU-facing signals of the sequencer.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// once valid is raised, the payload stays stable and valid stays high until that edge.
interface tinyalu_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_timeout;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_reset_n;
  logic        alu_done;
  logic [15:0] alu_result;
  logic [1:0]  dbg_state;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_done, alu_result,
    output cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_timeout,
           alu_a, alu_b, alu_op, alu_start, alu_reset_n, dbg_state
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_done, alu_result,
    input  cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_timeout,
           alu_a, alu_b, alu_op, alu_start, alu_reset_n, dbg_state
  );
endinterface

// File: rtl/tinyalu_sequencer.sv
// Buffers ALU commands in a FIFO, issues them one at a time to the TinyALU, and
// returns each result on a response channel; a watchdog aborts a stuck ALU operation.
module tinyalu_sequencer #(
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 8
) (
  input logic                 clk,
  input logic                 reset,
  tinyalu_sequencer_if.slave  bus
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  cmd_t          mem_q [CMD_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;

  state_e        state_q;
  logic [WW-1:0] wd_q;
  logic [WW-1:0] wd_d;

  logic [7:0]    alu_a_q;
  logic [7:0]    alu_b_q;
  logic [2:0]    alu_op_q;
  logic          alu_start_q;
  logic          rsp_valid_q;
  logic [15:0]   rsp_result_q;
  logic [2:0]    rsp_op_q;
  logic          rsp_timeout_q;

  logic          full;
  logic          empty;
  logic          cmd_ready_w;
  logic          push;
  logic          pop;
  cmd_t          head;

  assign full        = (count_q == (AW+1)'(CMD_DEPTH));
  assign empty       = (count_q == '0);
  assign cmd_ready_w = !full && !reset;
  assign push        = bus.cmd_valid && cmd_ready_w;
  assign pop         = (state_q == IDLE) && !empty;
  assign head        = mem_q[rd_ptr_q];
  assign wd_d        = wd_q + 1'b1;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // Storage is left unreset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      wd_q          <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= '0;
      alu_start_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_op_q      <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            alu_a_q  <= head.a;
            alu_b_q  <= head.b;
            alu_op_q <= head.op;
            rsp_op_q <= head.op;
            if (head.op == 3'b000) begin
              rsp_result_q  <= '0;
              rsp_timeout_q <= 1'b0;
              rsp_valid_q   <= 1'b1;
              state_q       <= RESP;
            end else begin
              alu_start_q <= 1'b1;
              wd_q        <= '0;
              state_q     <= BUSY;
            end
          end
        end
        BUSY: begin
          // start falls on the edge that samples done so the multiplier's chain drains.
          if (bus.alu_done) begin
            rsp_result_q  <= bus.alu_result;
            rsp_timeout_q <= 1'b0;
            alu_start_q   <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= RESP;
          end else begin
            wd_q <= wd_d;
            if (wd_d == WW'(TIMEOUT)) begin
              alu_start_q <= 1'b0;
              state_q     <= FLUSH;
            end
          end
        end
        FLUSH: begin
          rsp_result_q  <= '0;
          rsp_timeout_q <= 1'b1;
          rsp_valid_q   <= 1'b1;
          state_q       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_w;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_op      = rsp_op_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_start   = alu_start_q;
  assign bus.alu_reset_n = !(reset || (state_q == FLUSH));
  assign bus.dbg_state   = state_q;
endmodule
